// File: rtl/frame_scheduler_pkg.sv
// Shared screen geometry, VGA port widths and frame sequencer state encodings.
// The drawing engines import the same package.
package frame_scheduler_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_FPV_GO    = 3'd3,
    ST_FPV_WAIT  = 3'd4,
    ST_MAP_GO    = 3'd5,
    ST_MAP_WAIT  = 3'd6,
    ST_FRAME_END = 3'd7
  } state_t;
endpackage

// File: rtl/frame_scheduler_clear.sv
// Raster counter for the screen clear: x runs fastest, wraps to (0,0) after the last pixel.
module screen_clear_counter import frame_scheduler_pkg::*; #(
  parameter int W = 160,
  parameter int H = 120
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           step,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  logic x_end;

  assign x_end = (x == X_W'(W - 1));
  assign last  = x_end && (y == Y_W'(H - 1));

  always_ff @(posedge clock) begin
    if (reset || (step && last)) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_end) begin
        x <= '0;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end
endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: clear, then draw_fpv, then map overlay, each owning the VGA write port
// in turn. A watchdog aborts a drawer stage that never reports done.
module frame_scheduler import frame_scheduler_pkg::*; #(
  parameter int                  SCREEN_W     = 160,
  parameter int                  SCREEN_H     = 120,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0,
  parameter logic [31:0]         TIMEOUT      = 32'd2000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_tick,
  output logic                fpv_start,
  input  logic                fpv_done,
  input  logic [X_W-1:0]      fpv_x,
  input  logic [Y_W-1:0]      fpv_y,
  input  logic [COLOUR_W-1:0] fpv_colour,
  input  logic                fpv_write,
  output logic                map_start,
  input  logic                map_done,
  input  logic [X_W-1:0]      map_x,
  input  logic [Y_W-1:0]      map_y,
  input  logic [COLOUR_W-1:0] map_colour,
  input  logic                map_write,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_write,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);
  state_t        state;
  logic          tick_pending;
  logic [31:0]   wdog;
  logic          wdog_exp;
  logic [X_W-1:0] clr_x;
  logic [Y_W-1:0] clr_y;
  logic          clr_last;

  assign busy     = (state != ST_IDLE) && (state != ST_WAIT_TICK);
  assign wdog_exp = (wdog == TIMEOUT - 32'd1);

  screen_clear_counter #(.W(SCREEN_W), .H(SCREEN_H)) u_clear (
    .clock (clock),
    .reset (reset),
    .step  (state == ST_CLEAR),
    .x     (clr_x),
    .y     (clr_y),
    .last  (clr_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      tick_pending <= 1'b0;
      wdog         <= '0;
      fpv_start    <= 1'b0;
      map_start    <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      vga_write    <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      vga_write <= 1'b0;
      fpv_start <= 1'b0;
      map_start <= 1'b0;
      // A tick that lands mid-frame is remembered once; further ones are dropped.
      if (frame_tick && busy) begin
        overrun      <= 1'b1;
        tick_pending <= 1'b1;
      end
      case (state)
        ST_IDLE: if (enable) begin
          state <= ST_WAIT_TICK;
          if (frame_tick) tick_pending <= 1'b1;
        end
        ST_WAIT_TICK: begin
          if (frame_tick || tick_pending) begin
            state        <= ST_CLEAR;
            tick_pending <= 1'b0;
          end else if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          vga_x      <= clr_x;
          vga_y      <= clr_y;
          vga_colour <= CLEAR_COLOUR;
          vga_write  <= 1'b1;
          if (clr_last) begin
            state     <= ST_FPV_GO;
            fpv_start <= 1'b1;
          end
        end
        ST_FPV_GO: begin
          wdog  <= '0;
          state <= ST_FPV_WAIT;
        end
        ST_FPV_WAIT: begin
          vga_x      <= fpv_x;
          vga_y      <= fpv_y;
          vga_colour <= fpv_colour;
          vga_write  <= fpv_write;
          // done wins over a same-cycle watchdog expiry
          if (fpv_done || wdog_exp) begin
            state     <= ST_MAP_GO;
            map_start <= 1'b1;
            if (!fpv_done) timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        ST_MAP_GO: begin
          wdog  <= '0;
          state <= ST_MAP_WAIT;
        end
        ST_MAP_WAIT: begin
          vga_x      <= map_x;
          vga_y      <= map_y;
          vga_colour <= map_colour;
          vga_write  <= map_write;
          if (map_done || wdog_exp) begin
            state <= ST_FRAME_END;
            if (!map_done) timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        ST_FRAME_END: begin
          tick_pending <= 1'b0;
          if (!enable)                          state <= ST_IDLE;
          else if (tick_pending || frame_tick)  state <= ST_CLEAR;
          else                                  state <= ST_WAIT_TICK;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
